// File: rtl/branch_resolve_unit_if.sv
// Bus bundle between the fetch/resolve pipeline stages and the
// branch_resolve_unit: fetch-side BTB lookup, resolve-side outcome,
// BTB write port and redirect outputs.
interface branch_resolve_unit_if;
  logic        fetch_valid;
  logic [15:0] fetch_pc;
  logic        btb_hit;
  logic [15:0] btb_predicted_pc;
  logic        q_full;
  logic        resolve_valid;
  logic        resolve_is_br;
  logic        resolve_taken;
  logic [15:0] resolve_target;
  logic [15:0] btb_write_pc;
  logic [15:0] btb_write_data;
  logic        btb_taken;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        underflow;

  // Pipeline side: drives fetch/resolve info, observes the unit's results.
  modport master (
    output fetch_valid, fetch_pc, btb_hit, btb_predicted_pc,
    output resolve_valid, resolve_is_br, resolve_taken, resolve_target,
    input  q_full, btb_write_pc, btb_write_data, btb_taken,
    input  redirect, redirect_pc, underflow
  );

  // Unit side.
  modport slave (
    input  fetch_valid, fetch_pc, btb_hit, btb_predicted_pc,
    input  resolve_valid, resolve_is_br, resolve_taken, resolve_target,
    output q_full, btb_write_pc, btb_write_data, btb_taken,
    output redirect, redirect_pc, underflow
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: in-order queue of BTB lookups made at fetch, checked
// against the real branch outcome at resolve. Produces a registered BTB
// write pulse and a registered redirect pulse; a mispredict flushes the queue.
// Optional build macro BRU_PERF_CNT_EN adds saturating branch and
// mispredict counters (br_count, mispredict_count).
module branch_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  branch_resolve_unit_if.slave  bus
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [15:0]           br_count,
  output logic [15:0]           mispredict_count
`endif
);

  localparam logic [PTR_W:0]   FULL_C    = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_ZERO  = (PTR_W + 1)'(0);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);

  // Prediction storage, indexed by pointer
  logic [15:0]      pc_mem_q   [DEPTH];
  logic [15:0]      pred_mem_q [DEPTH];
  logic [DEPTH-1:0] hit_mem_q;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             q_full_q, q_full_d;
  logic             underflow_q, underflow_d;
  logic             redirect_q, btb_taken_q;
  logic [15:0]      redirect_pc_q, btb_write_pc_q, btb_write_data_q;

  logic             push_s, pop_s, mispredict_s, write_s, taken_br_s;
  logic [15:0]      head_pc_s, head_pred_s, pc_plus2_s, pred_next_s, act_next_s;
  logic             head_hit_s;

  // Head entry decode and prediction check
  always_comb begin
    push_s       = bus.fetch_valid & ~q_full_q;
    pop_s        = bus.resolve_valid & (count_q != CNT_ZERO);
    head_pc_s    = pc_mem_q[rd_ptr_q];
    head_pred_s  = pred_mem_q[rd_ptr_q];
    head_hit_s   = hit_mem_q[rd_ptr_q];
    pc_plus2_s   = head_pc_s + 16'd2;
    taken_br_s   = bus.resolve_is_br & bus.resolve_taken;
    pred_next_s  = head_hit_s ? head_pred_s : pc_plus2_s;
    act_next_s   = taken_br_s ? bus.resolve_target : pc_plus2_s;
    mispredict_s = pop_s & (pred_next_s != act_next_s);
    write_s      = pop_s & taken_br_s &
                   (~head_hit_s | (head_pred_s != bus.resolve_target));
  end

  // Pointer/count next state; a mispredict squashes everything incl. same-cycle push
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    underflow_d = underflow_q | (bus.resolve_valid & (count_q == CNT_ZERO));
    if (mispredict_s) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
    q_full_d = (count_d == FULL_C);
  end

  // Queue storage write on accepted push
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= 16'h0000;
        pred_mem_q[i] <= 16'h0000;
      end
      hit_mem_q <= '0;
    end else if (push_s) begin
      pc_mem_q[wr_ptr_q]   <= bus.fetch_pc;
      pred_mem_q[wr_ptr_q] <= bus.btb_predicted_pc;
      hit_mem_q[wr_ptr_q]  <= bus.btb_hit;
    end
  end

  // Queue control and registered result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q         <= PTR_ZERO;
      rd_ptr_q         <= PTR_ZERO;
      count_q          <= CNT_ZERO;
      q_full_q         <= 1'b0;
      underflow_q      <= 1'b0;
      redirect_q       <= 1'b0;
      redirect_pc_q    <= 16'h0000;
      btb_taken_q      <= 1'b0;
      btb_write_pc_q   <= 16'h0000;
      btb_write_data_q <= 16'h0000;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      q_full_q    <= q_full_d;
      underflow_q <= underflow_d;
      redirect_q  <= mispredict_s;
      btb_taken_q <= write_s;
      if (mispredict_s) begin
        redirect_pc_q <= act_next_s;
      end
      if (write_s) begin
        btb_write_pc_q   <= head_pc_s;
        btb_write_data_q <= bus.resolve_target;
      end
    end
  end

  assign bus.q_full         = q_full_q;
  assign bus.underflow      = underflow_q;
  assign bus.redirect       = redirect_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.btb_taken      = btb_taken_q;
  assign bus.btb_write_pc   = btb_write_pc_q;
  assign bus.btb_write_data = btb_write_data_q;

`ifdef BRU_PERF_CNT_EN
  logic [15:0] br_count_q, br_count_d, mp_count_q, mp_count_d;

  // Saturating performance counters
  always_comb begin
    br_count_d = br_count_q;
    mp_count_d = mp_count_q;
    if (pop_s & bus.resolve_is_br & (br_count_q != 16'hFFFF)) begin
      br_count_d = br_count_q + 16'd1;
    end else begin
      br_count_d = br_count_q;
    end
    if (mispredict_s & (mp_count_q != 16'hFFFF)) begin
      mp_count_d = mp_count_q + 16'd1;
    end else begin
      mp_count_d = mp_count_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      br_count_q <= 16'h0000;
      mp_count_q <= 16'h0000;
    end else begin
      br_count_q <= br_count_d;
      mp_count_q <= mp_count_d;
    end
  end

  assign br_count         = br_count_q;
  assign mispredict_count = mp_count_q;
`endif

endmodule
